// File: rtl/z80_decode_writeback.sv
// Decode/writeback stage for a register-only Z80 subset: assembles opcode and
// immediate bytes from a valid/ready byte stream and drives register-file write ports.
module z80_decode_writeback #(
    parameter logic [7:0]  REG_A  = 8'h00,
    parameter logic [7:0]  REG_B  = 8'h01,
    parameter logic [7:0]  REG_C  = 8'h02,
    parameter logic [7:0]  REG_D  = 8'h03,
    parameter logic [7:0]  REG_E  = 8'h04,
    parameter logic [7:0]  REG_H  = 8'h05,
    parameter logic [7:0]  REG_L  = 8'h06,
    parameter logic [15:0] REG_BC = 16'h07,
    parameter logic [15:0] REG_DE = 16'h08,
    parameter logic [15:0] REG_HL = 16'h09,
    parameter logic [15:0] REG_SP = 16'h10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    input  logic [7:0]  A,
    input  logic [7:0]  B,
    input  logic [7:0]  C,
    input  logic [7:0]  D,
    input  logic [7:0]  E,
    input  logic [7:0]  H,
    input  logic [7:0]  L,
    input  logic [7:0]  F,
    output logic        reg8_we,
    output logic [7:0]  reg8_dst,
    output logic [7:0]  reg8_data,
    output logic        reg16_we,
    output logic [15:0] reg16_dst,
    output logic [15:0] reg16_data,
    output logic        flags_we,
    output logic [7:0]  flags,
    output logic        instr_done,
    output logic        illegal_op,
    output logic        busy,
    output logic [2:0]  dbg_state
);

    // Byte handshake: a byte transfers on a rising edge where byte_valid && byte_ready.
    // byte_ready is high only in the three fetch states and never while reset is high.
    typedef enum logic [2:0] {
        FETCH_OP = 3'd0,
        FETCH_LO = 3'd1,
        FETCH_HI = 3'd2,
        WB       = 3'd3,
        ILLEGAL  = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] opcode_q, opcode_d;
    logic [7:0] lo_q, lo_d;
    logic [7:0] hi_q, hi_d;
    logic       accept;

    function automatic logic is_nop(input logic [7:0] op);
        return op == 8'h00;
    endfunction

    function automatic logic is_ld_r_n(input logic [7:0] op);
        return (op[7:6] == 2'b00) && (op[2:0] == 3'b110) && (op[5:3] != 3'b110);
    endfunction

    function automatic logic is_ld_rr_nn(input logic [7:0] op);
        return (op[7:6] == 2'b00) && (op[3:0] == 4'b0001);
    endfunction

    function automatic logic is_ld_r_r(input logic [7:0] op);
        return (op[7:6] == 2'b01) && (op[5:3] != 3'b110) && (op[2:0] != 3'b110);
    endfunction

    function automatic logic is_inc(input logic [7:0] op);
        return (op[7:6] == 2'b00) && (op[2:0] == 3'b100) && (op[5:3] != 3'b110);
    endfunction

    function automatic logic [7:0] code8(input logic [2:0] r);
        case (r)
            3'b000:  return REG_B;
            3'b001:  return REG_C;
            3'b010:  return REG_D;
            3'b011:  return REG_E;
            3'b100:  return REG_H;
            3'b101:  return REG_L;
            default: return REG_A;
        endcase
    endfunction

    function automatic logic [15:0] code16(input logic [1:0] rr);
        case (rr)
            2'b00:   return REG_BC;
            2'b01:   return REG_DE;
            2'b10:   return REG_HL;
            default: return REG_SP;
        endcase
    endfunction

    function automatic logic [7:0] reg_val(input logic [2:0] r, input logic [7:0] a,
                                           input logic [7:0] b, input logic [7:0] c,
                                           input logic [7:0] d, input logic [7:0] e,
                                           input logic [7:0] h, input logic [7:0] l);
        case (r)
            3'b000:  return b;
            3'b001:  return c;
            3'b010:  return d;
            3'b011:  return e;
            3'b100:  return h;
            3'b101:  return l;
            default: return a;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= FETCH_OP;
            opcode_q <= 8'h00;
            lo_q     <= 8'h00;
            hi_q     <= 8'h00;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
        end
    end

    assign accept = byte_valid && byte_ready;

    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        case (state_q)
            FETCH_OP: if (accept) begin
                opcode_d = byte_data;
                if (is_nop(byte_data) || is_ld_r_r(byte_data) || is_inc(byte_data))
                    state_d = WB;
                else if (is_ld_r_n(byte_data) || is_ld_rr_nn(byte_data))
                    state_d = FETCH_LO;
                else
                    state_d = ILLEGAL;
            end
            FETCH_LO: if (accept) begin
                lo_d    = byte_data;
                state_d = is_ld_rr_nn(opcode_q) ? FETCH_HI : WB;
            end
            FETCH_HI: if (accept) begin
                hi_d    = byte_data;
                state_d = WB;
            end
            default: state_d = FETCH_OP;
        endcase
    end

    logic [7:0] dst_cur;
    logic [7:0] src_cur;
    logic [7:0] inc_res;

    // Register values are read in the WB cycle, after any previous write has committed.
    assign dst_cur = reg_val(opcode_q[5:3], A, B, C, D, E, H, L);
    assign src_cur = reg_val(opcode_q[2:0], A, B, C, D, E, H, L);
    assign inc_res = dst_cur + 8'd1;

    always_comb begin
        byte_ready = 1'b0;
        busy       = (state_q != FETCH_OP);
        dbg_state  = state_q;
        reg8_we    = 1'b0;
        reg8_dst   = 8'h00;
        reg8_data  = 8'h00;
        reg16_we   = 1'b0;
        reg16_dst  = 16'h0000;
        reg16_data = 16'h0000;
        flags_we   = 1'b0;
        flags      = 8'h00;
        instr_done = 1'b0;
        illegal_op = 1'b0;
        case (state_q)
            FETCH_OP, FETCH_LO, FETCH_HI: byte_ready = !reset;
            WB: begin
                instr_done = 1'b1;
                if (is_ld_r_n(opcode_q)) begin
                    reg8_we   = 1'b1;
                    reg8_dst  = code8(opcode_q[5:3]);
                    reg8_data = lo_q;
                end else if (is_ld_rr_nn(opcode_q)) begin
                    reg16_we   = 1'b1;
                    reg16_dst  = code16(opcode_q[5:4]);
                    reg16_data = {hi_q, lo_q};
                end else if (is_ld_r_r(opcode_q)) begin
                    reg8_we   = 1'b1;
                    reg8_dst  = code8(opcode_q[5:3]);
                    reg8_data = src_cur;
                end else if (is_inc(opcode_q)) begin
                    reg8_we   = 1'b1;
                    reg8_dst  = code8(opcode_q[5:3]);
                    reg8_data = inc_res;
                    flags_we  = 1'b1;
                    flags     = {inc_res[7], inc_res == 8'h00, inc_res[5],
                                 dst_cur[3:0] == 4'hF, inc_res[3],
                                 dst_cur == 8'h7F, 1'b0, F[0]};
                end
            end
            ILLEGAL: illegal_op = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_z80_decode_writeback.sv
// Directed bench for z80_decode_writeback: byte streams with hand-computed
// register-file writes, backpressure gaps, illegal opcodes and mid-instruction reset.
module tb_z80_decode_writeback;
  logic        clk = 1'b0;
  logic        reset;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic [7:0]  A, B, C, D, E, H, L, F;
  logic        reg8_we;
  logic [7:0]  reg8_dst, reg8_data;
  logic        reg16_we;
  logic [15:0] reg16_dst, reg16_data;
  logic        flags_we;
  logic [7:0]  flags;
  logic        instr_done, illegal_op, busy;
  logic [2:0]  dbg_state;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  z80_decode_writeback dut (
    .clk(clk), .reset(reset), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .A(A), .B(B), .C(C), .D(D), .E(E), .H(H), .L(L), .F(F),
    .reg8_we(reg8_we), .reg8_dst(reg8_dst), .reg8_data(reg8_data),
    .reg16_we(reg16_we), .reg16_dst(reg16_dst), .reg16_data(reg16_data),
    .flags_we(flags_we), .flags(flags), .instr_done(instr_done),
    .illegal_op(illegal_op), .busy(busy), .dbg_state(dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    byte_valid = 1'b1;
    byte_data  = b;
    tick();
    byte_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; byte_valid = 1'b0; byte_data = 8'h00;
    A = 8'h00; B = 8'h00; C = 8'h00; D = 8'h00;
    E = 8'h00; H = 8'h00; L = 8'h00; F = 8'h00;
    tick();
    tick();
    check("rst_ready", {31'd0, byte_ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_pulses", {27'd0, reg8_we, reg16_we, flags_we, instr_done, illegal_op}, 32'd0);
    check("rst_r8", {16'd0, reg8_dst, reg8_data}, 32'd0);
    check("rst_r16", {reg16_dst, reg16_data}, 32'd0);
    check("rst_flags", {24'd0, flags}, 32'd0);
    reset = 1'b0;
    #1;
    check("idle_ready", {31'd0, byte_ready}, 32'd1);

    // LD B,5A back-to-back
    send(8'h06);
    send(8'h5A);
    check("ldrn_we", {29'd0, reg8_we, reg16_we, flags_we}, 32'b100);
    check("ldrn_dst", {24'd0, reg8_dst}, 32'h01);
    check("ldrn_data", {24'd0, reg8_data}, 32'h5A);
    check("ldrn_done", {31'd0, instr_done}, 32'd1);
    check("ldrn_ready", {31'd0, byte_ready}, 32'd0);
    tick();
    check("ldrn_after_busy", {31'd0, busy}, 32'd0);
    check("ldrn_after_done", {31'd0, instr_done}, 32'd0);

    // LD HL,1234 with three idle cycles between bytes
    send(8'h21);
    check("ldrr_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ldrr_gap1", {29'd0, reg8_we, reg16_we, instr_done}, 32'd0);
    end
    send(8'h34);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ldrr_gap2", {29'd0, reg8_we, reg16_we, instr_done}, 32'd0);
    end
    send(8'h12);
    check("ldrr_we", {29'd0, reg8_we, reg16_we, flags_we}, 32'b010);
    check("ldrr_dst", {16'd0, reg16_dst}, 32'h0009);
    check("ldrr_data", {16'd0, reg16_data}, 32'h1234);
    check("ldrr_done", {31'd0, instr_done}, 32'd1);
    tick();
    check("ldrr_after", {30'd0, reg16_we, busy}, 32'd0);

    // INC A overflow 7F -> 80, carry preserved
    A = 8'h7F; F = 8'h01;
    send(8'h3C);
    check("inc7f_dst", {24'd0, reg8_dst}, 32'h00);
    check("inc7f_data", {24'd0, reg8_data}, 32'h80);
    check("inc7f_we", {29'd0, reg8_we, reg16_we, flags_we}, 32'b101);
    check("inc7f_flags", {24'd0, flags}, 32'h95);
    tick();

    // INC A wrap FF -> 00
    A = 8'hFF; F = 8'h00;
    send(8'h3C);
    check("incff_data", {24'd0, reg8_data}, 32'h00);
    check("incff_flags", {24'd0, flags}, 32'h50);
    tick();

    // LD A,B
    B = 8'h5A;
    send(8'h78);
    check("ldrr8_dst", {24'd0, reg8_dst}, 32'h00);
    check("ldrr8_data", {24'd0, reg8_data}, 32'h5A);
    check("ldrr8_we", {29'd0, reg8_we, reg16_we, flags_we}, 32'b100);
    tick();

    // LD (HL),n is illegal
    send(8'h36);
    check("ill36_pulse", {31'd0, illegal_op}, 32'd1);
    check("ill36_strobes", {29'd0, reg8_we, reg16_we, flags_we}, 32'd0);
    check("ill36_done", {31'd0, instr_done}, 32'd0);
    check("ill36_ready", {31'd0, byte_ready}, 32'd0);
    tick();
    check("ill36_next", {29'd0, busy, illegal_op, byte_ready}, 32'b001);

    // HALT is illegal
    send(8'h76);
    check("ill76_pulse", {31'd0, illegal_op}, 32'd1);
    check("ill76_strobes", {29'd0, reg8_we, reg16_we, instr_done}, 32'd0);
    tick();

    // LD SP,nn interrupted by reset
    send(8'h31);
    send(8'hCD);
    check("rstmid_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    tick();
    check("rstmid_ready", {31'd0, byte_ready}, 32'd0);
    check("rstmid_state", {30'd0, busy, reg16_we}, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rstmid_no_wr", {29'd0, reg16_we, reg8_we, busy}, 32'd0);
    end
    send(8'h00);
    check("nop_done", {31'd0, instr_done}, 32'd1);
    check("nop_strobes", {28'd0, reg8_we, reg16_we, flags_we, illegal_op}, 32'd0);
    tick();

    // LD B,11 then INC B with byte_valid held high
    B = 8'h00; F = 8'h00;
    byte_valid = 1'b1;
    byte_data = 8'h06;
    tick();
    byte_data = 8'h11;
    tick();
    check("strm_ld_we", {31'd0, reg8_we}, 32'd1);
    check("strm_ld_dst", {24'd0, reg8_dst}, 32'h01);
    check("strm_ld_data", {24'd0, reg8_data}, 32'h11);
    check("strm_ld_ready", {31'd0, byte_ready}, 32'd0);
    byte_data = 8'h04;
    tick();
    B = 8'h11;
    check("strm_fetch", {30'd0, busy, byte_ready}, 32'b01);
    tick();
    check("strm_inc_dst", {24'd0, reg8_dst}, 32'h01);
    check("strm_inc_data", {24'd0, reg8_data}, 32'h12);
    check("strm_inc_fwe", {31'd0, flags_we}, 32'd1);
    check("strm_inc_flags", {24'd0, flags}, 32'h00);
    check("strm_inc_ready", {31'd0, byte_ready}, 32'd0);
    byte_valid = 1'b0;
    tick();
    check("strm_end", {30'd0, busy, instr_done}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
